// File: rtl/kernel_bc_fifo_pkg.sv
// kernel_bc_fifo_pkg: shared helpers and defaults for the parametrised kernel_bc FIFO.
package kernel_bc_fifo_pkg;

    localparam int DEF_AFULL_MARGIN  = 2;
    localparam int DEF_AEMPTY_THRESH = 2;

    // Pointer increment that wraps at an arbitrary depth, not just a power of two.
    function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input int depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/kernel_bc_fifo_param_mem.sv
// kernel_bc_fifo_param_mem: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read.
module kernel_bc_fifo_param_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/kernel_bc_fifo_param.sv
// kernel_bc_fifo_param: first-word fall-through FIFO of any depth with count,
// threshold flags, synchronous flush and sticky overflow/underflow.
module kernel_bc_fifo_param
    import kernel_bc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 16,
    parameter int ADDR_WIDTH    = $clog2(DEPTH),
    parameter int AFULL_THRESH  = DEPTH - DEF_AFULL_MARGIN,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_flush,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  if_almost_full_n,
    output logic                  if_almost_empty_n,
    output logic                  if_overflow,
    output logic                  if_underflow
);

    localparam int CW = cnt_width(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic empty_n_q, empty_n_d, full_n_q, full_n_d;
    logic afull_n_q, afull_n_d, aempty_n_q, aempty_n_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic wr_req, rd_req, wr_en, rd_en;

    always_comb begin
        wr_req     = if_write & if_write_ce;
        rd_req     = if_read & if_read_ce;
        wr_en      = wr_req & full_n_q & ~if_flush;
        rd_en      = rd_req & empty_n_q & ~if_flush;
        wr_ptr_d   = wr_en ? ADDR_WIDTH'(ptr_next(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
        rd_ptr_d   = rd_en ? ADDR_WIDTH'(ptr_next(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
        count_d    = (wr_en && !rd_en) ? count_q + 1'b1 :
                     (rd_en && !wr_en) ? count_q - 1'b1 : count_q;
        ovf_d      = ovf_q | (wr_req & ~full_n_q);
        unf_d      = unf_q | (rd_req & ~empty_n_q);
        if (if_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end
        // Flags come from the next count so they line up with if_count.
        empty_n_d  = count_d != '0;
        full_n_d   = int'(count_d) != DEPTH;
        afull_n_d  = !(int'(count_d) >= AFULL_THRESH);
        aempty_n_d = !(int'(count_d) <= AEMPTY_THRESH);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_n_q  <= 1'b0;
            full_n_q   <= 1'b1;
            afull_n_q  <= AFULL_THRESH != 0;
            aempty_n_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_n_q  <= empty_n_d;
            full_n_q   <= full_n_d;
            afull_n_q  <= afull_n_d;
            aempty_n_q <= aempty_n_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    kernel_bc_fifo_param_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_en & reset),
        .waddr(wr_ptr_q),
        .wdata(if_din),
        .raddr(rd_ptr_q),
        .rdata(if_dout)
    );

    assign if_empty_n        = empty_n_q;
    assign if_full_n         = full_n_q;
    assign if_count          = count_q;
    assign if_almost_full_n  = afull_n_q;
    assign if_almost_empty_n = aempty_n_q;
    assign if_overflow       = ovf_q;
    assign if_underflow      = unf_q;

endmodule

// File: tb/tb_kernel_bc_fifo_param.sv
// tb_kernel_bc_fifo_param: directed checks of a DEPTH=5 FIFO with hand-computed expectations.
module tb_kernel_bc_fifo_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       if_empty_n, if_full_n, if_almost_full_n, if_almost_empty_n;
    logic       if_overflow, if_underflow;
    logic       if_read_ce, if_read, if_write_ce, if_write, if_flush;
    logic [7:0] if_dout, if_din;
    logic [3:0] if_count;
    int         n_chk = 0;
    int         n_pass = 0;

    kernel_bc_fifo_param #(
        .DATA_WIDTH  (8),
        .DEPTH       (5),
        .AFULL_THRESH(3)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .if_empty_n       (if_empty_n),
        .if_read_ce       (if_read_ce),
        .if_read          (if_read),
        .if_dout          (if_dout),
        .if_full_n        (if_full_n),
        .if_write_ce      (if_write_ce),
        .if_write         (if_write),
        .if_din           (if_din),
        .if_flush         (if_flush),
        .if_count         (if_count),
        .if_almost_full_n (if_almost_full_n),
        .if_almost_empty_n(if_almost_empty_n),
        .if_overflow      (if_overflow),
        .if_underflow     (if_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; if_read = 1'b0; if_read_ce = 1'b1; if_write = 1'b1;
        if_write_ce = 1'b1; if_flush = 1'b0; if_din = 8'h99;
        repeat (3) step();
        check("rst_count", 32'(if_count), 32'd0);
        check("rst_empty_n", 32'(if_empty_n), 32'd0);
        check("rst_full_n", 32'(if_full_n), 32'd1);
        check("rst_ovf", 32'(if_overflow), 32'd0);
        check("rst_afull_n", 32'(if_almost_full_n), 32'd1);
        check("rst_aempty_n", 32'(if_almost_empty_n), 32'd0);
        reset = 1'b1; if_write = 1'b0;
        step();
        check("rel_empty_n", 32'(if_empty_n), 32'd0);
        check("rel_count", 32'(if_count), 32'd0);

        for (int i = 0; i < 5; i++) begin
            if_write = 1'b1; if_din = 8'(8'h11 + i);
            step();
            check("fill_count", 32'(if_count), 32'(i + 1));
            check("fill_empty_n", 32'(if_empty_n), 32'd1);
            check("fill_full_n", 32'(if_full_n), (i == 4) ? 32'd0 : 32'd1);
            check("fill_afull_n", 32'(if_almost_full_n), (i >= 2) ? 32'd0 : 32'd1);
            check("fill_aempty_n", 32'(if_almost_empty_n), (i >= 2) ? 32'd1 : 32'd0);
            check("fill_dout", 32'(if_dout), 32'h11);
        end
        if_din = 8'h16;
        step();
        check("ovf_set", 32'(if_overflow), 32'd1);
        check("ovf_count", 32'(if_count), 32'd5);
        check("ovf_dout", 32'(if_dout), 32'h11);

        if_read = 1'b1; if_din = 8'h17;
        step();
        check("fullrw_count", 32'(if_count), 32'd4);
        check("fullrw_full_n", 32'(if_full_n), 32'd1);
        check("fullrw_dout", 32'(if_dout), 32'h12);
        check("fullrw_ovf", 32'(if_overflow), 32'd1);
        if_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("drain_dout", 32'(if_dout), 32'(8'h12 + i));
            step();
        end
        check("drain_count", 32'(if_count), 32'd0);
        check("drain_empty_n", 32'(if_empty_n), 32'd0);

        step();
        check("unf_set", 32'(if_underflow), 32'd1);
        check("unf_count", 32'(if_count), 32'd0);
        if_read = 1'b0; if_write = 1'b1; if_din = 8'hA5;
        step();
        check("a5_empty_n", 32'(if_empty_n), 32'd1);
        check("a5_dout", 32'(if_dout), 32'hA5);
        check("a5_count", 32'(if_count), 32'd1);

        if_din = 8'h21; step();
        if_din = 8'h22; step();
        check("preflush_count", 32'(if_count), 32'd3);
        if_flush = 1'b1; if_din = 8'h33;
        step();
        check("flush_count", 32'(if_count), 32'd0);
        check("flush_empty_n", 32'(if_empty_n), 32'd0);
        check("flush_ovf", 32'(if_overflow), 32'd0);
        check("flush_unf", 32'(if_underflow), 32'd0);
        check("flush_full_n", 32'(if_full_n), 32'd1);
        check("flush_afull_n", 32'(if_almost_full_n), 32'd1);
        if_flush = 1'b0; if_din = 8'h44;
        step();
        check("postflush_dout", 32'(if_dout), 32'h44);
        check("postflush_count", 32'(if_count), 32'd1);

        if_din = 8'h45; step();
        if_read = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if_din = 8'(8'h50 + i);
            check("wrap_dout", 32'(if_dout), (i == 0) ? 32'h44 : (i == 1) ? 32'h45 : 32'(8'h50 + i - 2));
            step();
            check("wrap_count", 32'(if_count), 32'd2);
        end
        check("wrap_head", 32'(if_dout), 32'h5A);

        if_read_ce = 1'b0; if_write_ce = 1'b0;
        step();
        check("ce_count", 32'(if_count), 32'd2);
        check("ce_dout", 32'(if_dout), 32'h5A);
        if_read_ce = 1'b1; if_write_ce = 1'b1; if_read = 1'b0;
        reset = 1'b0;
        step();
        check("midrst_count", 32'(if_count), 32'd0);
        check("midrst_empty_n", 32'(if_empty_n), 32'd0);
        reset = 1'b1; if_write = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/kernel_bc_fifo_param.md
Name: kernel_bc_fifo_param

Overview:
Parametrised synchronous FIFO that generalises the kernel_bc stream FIFOs to arbitrary width and depth, including depths that are not a power of two. Uses a circular buffer with read/write pointers and keeps the same empty_n/full_n stream handshake. Adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. Sits between kernel_bc dataflow stages wherever a buffer deeper than 2 entries or back-pressure look-ahead is required.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
DEPTH, 16, number of entries (>=2, any integer)
ADDR_WIDTH, $clog2(DEPTH), pointer width (derived; do not override)
AFULL_THRESH, DEPTH-2, almost_full_n goes low when count >= AFULL_THRESH
AEMPTY_THRESH, 2, almost_empty_n goes low when count <= AEMPTY_THRESH

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous reset, active-low (reset==0 resets)
if_empty_n  out  1  1 = at least one entry readable
if_read_ce  in  1  read clock-enable
if_read  in  1  read request
if_dout  out  DATA_WIDTH  head entry; valid while if_empty_n=1
if_full_n  out  1  1 = at least one free entry
if_write_ce  in  1  write clock-enable
if_write  in  1  write request
if_din  in  DATA_WIDTH  write data
if_flush  in  1  synchronous clear of contents
if_count  out  ADDR_WIDTH+1  current occupancy 0..DEPTH
if_almost_full_n  out  1  0 when count >= AFULL_THRESH
if_almost_empty_n  out  1  0 when count <= AEMPTY_THRESH
if_overflow  out  1  sticky: write attempted while full
if_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (reset==0 at clk edge): wr_ptr=rd_ptr=0, count=0, if_empty_n=0, if_full_n=1, if_almost_empty_n=0, if_almost_full_n=1 (0 if AFULL_THRESH==0), if_overflow=0, if_underflow=0. Storage contents not reset. Reset overrides every other input, including mid-burst.
- wr_en = if_write & if_write_ce & if_full_n; rd_en = if_read & if_read_ce & if_empty_n.
- wr_en: mem[wr_ptr] <= if_din; wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
- rd_en: rd_ptr wraps identically; no data register on the read side.
- if_dout = mem[rd_ptr], combinational (first-word fall-through); undefined while if_empty_n=0.
- count: +1 on wr_en only, -1 on rd_en only, unchanged when both or neither.
- All flags are registered and derived from next-count: empty_n = (next!=0), full_n = (next!=DEPTH), thresholds likewise. Output flags are therefore exact in the same cycle as if_count.
- Latency: write into empty FIFO -> if_empty_n=1 and if_dout valid the next cycle; no write-to-read bypass.
- Full: write is ignored even when a read is accepted in the same cycle (full_n gates the write, as in existing FIFOs); full_n returns to 1 the cycle after the read.
- Empty: a read request is ignored; a simultaneous write is accepted.
- Overflow: if_write&if_write_ce while if_full_n=0 sets if_overflow. Underflow: if_read&if_read_ce while if_empty_n=0 sets if_underflow. Both hold until reset or flush.
- Flush (if_flush=1, reset inactive): same register values as reset, error flags cleared; wr_en/rd_en in that cycle are discarded. Priority: reset > flush > read/write.
- if_read_ce=0 / if_write_ce=0 freeze the respective side exactly as if the request were 0.

Decomposition:
- Shared package kernel_bc_fifo_pkg: ptr_next wrap function (wrap at DEPTH), count-width helper, default threshold constants.
- One sub-module: kernel_bc_fifo_param_mem — DEPTH x DATA_WIDTH storage, single synchronous write port, asynchronous read port. Pointers, count and flags stay in the top level.

Test Plan:
- Reset: hold reset=0 3 cycles with write=1 -> count=0, empty_n=0, full_n=1, no overflow; release, still empty.
- DEPTH=5, write 0x11..0x15 back-to-back -> full_n=0 the cycle after 5th write, count=5, almost_full_n=0 after the 3rd write (AFULL_THRESH=3); 6th write sets if_overflow=1, count stays 5.
- Wrap: DEPTH=5, loop 12 cycles of write i / read concurrently after prefill of 2 -> dout sequence strictly in order, count constant at 2, pointers wrap past index 4 without loss.
- Full with simultaneous read+write -> read accepted, write dropped, count 5->4, full_n=1 next cycle, overflow set.
- Empty read -> if_underflow=1, count stays 0; then single write 0xA5 -> empty_n=1 and dout=0xA5 one cycle later.
- Flush at count=3 with concurrent write -> next cycle count=0, empty_n=0, overflow/underflow=0, written word discarded.
